bcd_scan_counter: RTL

//  Parametrised N-digit synchronous BCD up/down counter with integrated multiplexed

---
 rtl/bcd_disp_pkg.sv | 33 +++
 rtl/bcd_scan_counter_tick_gen.sv | 27 ++
 rtl/bcd_scan_counter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Seven-segment glyph constants and the BCD-to-segment decoder.
// Segments are ordered {a,b,c,d,e,f,g,dp}, active-low, and dp is always off.
package bcd_disp_pkg;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_scan_counter_tick_gen.sv
// Free-running prescaler 0..DIV-1; tick is high for the single cycle at DIV-1.
// DIV=1 degenerates to a permanently asserted tick.
module tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_in,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with load and wrap pulse, plus a multiplexed seven-segment scanner.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_counter
  import bcd_disp_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned CNT_DIV  = 10_000_000,
  parameter int unsigned SCAN_DIV = 2_000
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  stop,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int unsigned CW    = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic              cnt_tick;
  logic              scan_tick;
  logic [CW-1:0]     count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic [CW-1:0]     load_sat;
  logic [CW-1:0]     step_val;
  logic              wrap_step;
  logic [DIGITS-1:0] at_lim;
  logic [DIGITS-1:0] is_zero;
  logic [3:0]        dig   [DIGITS];
  logic [3:0]        moved [DIGITS];

  tick_gen #(.DIV(CNT_DIV)) u_cnt_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .tick   (cnt_tick)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .tick   (scan_tick)
  );

  // Per-digit pieces; the carry/borrow chain itself is resolved below.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign dig[k]     = count_q[4*k +: 4];
    assign is_zero[k] = (dig[k] == 4'd0);
    assign at_lim[k]  = up_dn ? (dig[k] == 4'd9) : is_zero[k];
    assign moved[k]   = up_dn ? ((dig[k] == 4'd9) ? 4'd0 : dig[k] + 4'd1)
                              : (is_zero[k]       ? 4'd9 : dig[k] - 4'd1);
    assign load_sat[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd9 : load_val[4*k +: 4];
  end

  always_comb begin
    logic run;
    run      = 1'b1;
    step_val = count_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (run) step_val[4*k +: 4] = moved[k];
      run = run & at_lim[k];
    end
    wrap_step = run;
  end

`ifdef BCD_SCAN_LZB_EN
  logic [DIGITS-1:0] blank;

  // A position blanks only when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    logic zrun;
    zrun  = 1'b1;
    blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zrun     = zrun & is_zero[k];
      blank[k] = zrun && (k != 0);
    end
  end
`endif

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_sat;
    end else if (cnt_tick && !stop) begin
      count_d = step_val;
      wrap_d  = wrap_step;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (scan_tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // an and seg are both derived from the same idx_q so they always move together.
  always_comb begin
    an_d = ~(DIGITS'(1) << idx_q);
`ifdef BCD_SCAN_LZB_EN
    seg_d = blank[idx_q] ? SEG_BLANK : seg_decode(dig[idx_q]);
`else
    seg_d = seg_decode(dig[idx_q]);
`endif
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule
